// File: rtl/bsg_manycore_host_arb_pkg.sv
// bsg_manycore_host_arb_pkg: shared state enums and reg_id helper for the host request arbiter
package bsg_manycore_host_arb_pkg;
  typedef enum logic {eEMPTY, eFULL} obuf_state_e;
  typedef enum logic [1:0] {eRUN, eDRAIN, eQUIESCED} mode_e;
  function automatic int host_arb_src_id(input logic [31:0] reg_id, input int reg_id_width, input int lg_num);
    return int'(reg_id >> (reg_id_width - lg_num)) & ((1 << lg_num) - 1);
  endfunction
endpackage

// File: rtl/bsg_arb_round_robin.sv
// bsg_arb_round_robin: round-robin grant picker; search starts after the last accepted grant
module bsg_arb_round_robin #(
  parameter int width_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       grants_en_i,
  input  logic [width_p-1:0]         reqs_i,
  output logic [width_p-1:0]         grants_o,
  output logic [$clog2(width_p)-1:0] tag_o,
  input  logic                       yumi_i
);
  localparam int lg_lp = $clog2(width_p);
  logic [lg_lp-1:0] last_q, last_d, idx;
  logic [width_p-1:0] sel;
  logic found;
  always_comb begin
    sel = '0;
    tag_o = '0;
    found = 1'b0;
    idx = '0;
    for (int j = 1; j <= width_p; j++) begin
      idx = last_q + lg_lp'(j);
      if (!found && reqs_i[idx]) begin
        found = 1'b1;
        sel[idx] = 1'b1;
        tag_o = idx;
      end
    end
  end
  assign grants_o = grants_en_i ? sel : '0;
  assign last_d = yumi_i ? tag_o : last_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) last_q <= lg_lp'(width_p - 1);
    else last_q <= last_d;
endmodule

// File: rtl/bsg_manycore_host_req_arbiter.sv
// bsg_manycore_host_req_arbiter: credit-aware round-robin sharing of the host endpoint,
// with reg_id source stamping, response routing and quiesce/drain control
module bsg_manycore_host_req_arbiter
  import bsg_manycore_host_arb_pkg::*;
#(
  parameter int num_req_p         = 4,
  parameter int payload_width_p   = 96,
  parameter int data_width_p      = 32,
  parameter int reg_id_width_p    = 5,
  parameter int max_out_credits_p = 16,
  parameter int per_req_credits_p = 8,
  localparam int lg_n_lp = $clog2(num_req_p),
  localparam int lw_lp   = reg_id_width_p - lg_n_lp
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_req_p-1:0]                      req_v_i,
  input  logic [num_req_p-1:0][payload_width_p-1:0] req_payload_i,
  input  logic [num_req_p-1:0][lw_lp-1:0]           req_reg_id_i,
  output logic [num_req_p-1:0]                      req_ready_o,
  output logic                                      out_v_o,
  output logic [payload_width_p-1:0]                out_payload_o,
  output logic [reg_id_width_p-1:0]                 out_reg_id_o,
  input  logic                                      out_ready_i,
  input  logic                                      ret_v_i,
  input  logic [reg_id_width_p-1:0]                 ret_reg_id_i,
  input  logic [data_width_p-1:0]                   ret_data_i,
  output logic [num_req_p-1:0]                      ret_v_o,
  output logic [lw_lp-1:0]                          ret_reg_id_o,
  output logic [data_width_p-1:0]                   ret_data_o,
  input  logic                                      quiesce_i,
  output logic                                      idle_o,
  output logic                                      ret_err_o
);
  localparam int ocw_lp = $clog2(per_req_credits_p + 1);
  localparam int tcw_lp = $clog2(max_out_credits_p + 1);
  obuf_state_e obuf_q, obuf_d;
  mode_e mode_q, mode_d;
  logic [payload_width_p-1:0] pay_q, pay_d;
  logic [reg_id_width_p-1:0] rid_q, rid_d;
  logic [num_req_p-1:0][ocw_lp-1:0] out_cnt_q, out_cnt_d, out_post;
  logic [tcw_lp-1:0] tot_q, tot_d, tot_post;
  logic ret_err_q, ret_err_d;
  logic [lg_n_lp-1:0] ret_src, gnt_tag;
  logic [num_req_p-1:0] elig, ret_dec;
  logic drain, can_load, accept, ret_bad;
  assign ret_src = lg_n_lp'(host_arb_src_id(32'(ret_reg_id_i), reg_id_width_p, lg_n_lp));
  assign ret_bad = ret_v_i & (out_cnt_q[ret_src] == '0);
  assign drain = out_v_o & out_ready_i;
  assign can_load = (obuf_q == eEMPTY) | drain;
  assign accept = |req_ready_o;
  // eligibility uses post-return counts so a freed credit is reusable in the same cycle
  always_comb begin
    ret_dec = '0;
    out_post = '0;
    elig = '0;
    out_cnt_d = '0;
    for (int i = 0; i < num_req_p; i++) begin
      ret_dec[i] = ret_v_i & (ret_src == lg_n_lp'(i)) & (out_cnt_q[i] != '0);
      out_post[i] = out_cnt_q[i] - ocw_lp'(ret_dec[i]);
    end
    tot_post = tot_q - tcw_lp'(|ret_dec);
    for (int i = 0; i < num_req_p; i++) begin
      elig[i] = req_v_i[i] & (out_post[i] < ocw_lp'(per_req_credits_p))
              & (tot_post < tcw_lp'(max_out_credits_p)) & (mode_q == eRUN);
      out_cnt_d[i] = out_post[i] + ocw_lp'(req_ready_o[i]);
    end
    tot_d = tot_post + tcw_lp'(accept);
    obuf_d = accept ? eFULL : (drain ? eEMPTY : obuf_q);
    pay_d = accept ? req_payload_i[gnt_tag] : pay_q;
    rid_d = accept ? {gnt_tag, req_reg_id_i[gnt_tag]} : rid_q;
    ret_err_d = ret_err_q | ret_bad;
    mode_d = !quiesce_i ? eRUN
           : (mode_q == eRUN) ? eDRAIN
           : ((obuf_d == eEMPTY) && (tot_d == '0)) ? eQUIESCED : mode_q;
  end
  bsg_arb_round_robin #(.width_p(num_req_p)) rr (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .grants_en_i (can_load & ~reset_i),
    .reqs_i      (elig),
    .grants_o    (req_ready_o),
    .tag_o       (gnt_tag),
    .yumi_i      (accept)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      obuf_q <= eEMPTY;
      mode_q <= eRUN;
      pay_q <= '0;
      rid_q <= '0;
      out_cnt_q <= '0;
      tot_q <= '0;
      ret_err_q <= 1'b0;
    end else begin
      obuf_q <= obuf_d;
      mode_q <= mode_d;
      pay_q <= pay_d;
      rid_q <= rid_d;
      out_cnt_q <= out_cnt_d;
      tot_q <= tot_d;
      ret_err_q <= ret_err_d;
    end
  assign out_v_o = obuf_q == eFULL;
  assign out_payload_o = pay_q;
  assign out_reg_id_o = rid_q;
  assign ret_v_o = ret_v_i ? num_req_p'(1) << ret_src : '0;
  assign ret_reg_id_o = ret_reg_id_i[lw_lp-1:0];
  assign ret_data_o = ret_data_i;
  assign idle_o = mode_q == eQUIESCED;
  assign ret_err_o = ret_err_q;
endmodule

// File: tb/tb_bsg_manycore_host_req_arbiter.sv
// tb_bsg_manycore_host_req_arbiter: directed scenario tests for the host request arbiter
module tb_bsg_manycore_host_req_arbiter;
  localparam int N = 4, PW = 96, DW = 32, RW = 5, LW = 3;
  logic clk_i = 1'b0, reset_i;
  logic [N-1:0] req_v_i, req_ready_o, ret_v_o;
  logic [N-1:0][PW-1:0] req_payload_i;
  logic [N-1:0][LW-1:0] req_reg_id_i;
  logic out_v_o, out_ready_i, ret_v_i, quiesce_i, idle_o, ret_err_o;
  logic [PW-1:0] out_payload_o;
  logic [RW-1:0] out_reg_id_o, ret_reg_id_i;
  logic [DW-1:0] ret_data_i, ret_data_o;
  logic [LW-1:0] ret_reg_id_o;
  logic [PW-1:0] pay_tbl [N];
  logic [LW-1:0] lid_tbl [N];
  int tests = 0, fails = 0;

  bsg_manycore_host_req_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_v_i(req_v_i), .req_payload_i(req_payload_i),
    .req_reg_id_i(req_reg_id_i), .req_ready_o(req_ready_o), .out_v_o(out_v_o),
    .out_payload_o(out_payload_o), .out_reg_id_o(out_reg_id_o), .out_ready_i(out_ready_i),
    .ret_v_i(ret_v_i), .ret_reg_id_i(ret_reg_id_i), .ret_data_i(ret_data_i), .ret_v_o(ret_v_o),
    .ret_reg_id_o(ret_reg_id_o), .ret_data_o(ret_data_o), .quiesce_i(quiesce_i),
    .idle_o(idle_o), .ret_err_o(ret_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ret_n(input int src, input int n);
    for (int r = 0; r < n; r++) begin
      ret_v_i = 1'b1;
      ret_reg_id_i = {2'(src), 3'b000};
      step();
    end
    ret_v_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (out_v_o !== 1'b0) begin fails++; $display("FAIL reset_out_v got %b exp 0", out_v_o); end
    tests++; if (req_ready_o !== 4'b0) begin fails++; $display("FAIL reset_ready got %b exp 0000", req_ready_o); end
    tests++; if (ret_err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", ret_err_o); end
    tests++; if (idle_o !== 1'b0) begin fails++; $display("FAIL reset_idle got %b exp 0", idle_o); end
    req_v_i = '0;
    #10 reset_i = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    out_ready_i = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      req_v_i = (k < 8) ? 4'b1111 : 4'b0000;
      ret_v_i = (k >= 2 && k <= 9);
      ret_reg_id_i = {2'((k - 2) % 4), lid_tbl[(k + 2) % 4]};
      ret_data_i = 32'(k);
      #1;
      if (k < 8) begin
        tests++; if (req_ready_o !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rr_grant k=%0d got %b exp %b", k, req_ready_o, 4'(1 << (k % 4))); end
      end
      if (k >= 1 && k <= 8) begin
        tests++; if (out_v_o !== 1'b1 || out_reg_id_o !== {2'((k - 1) % 4), lid_tbl[(k - 1) % 4]})
          begin fails++; $display("FAIL rr_out k=%0d got v=%b id=%b exp v=1 id=%b", k, out_v_o, out_reg_id_o, {2'((k - 1) % 4), lid_tbl[(k - 1) % 4]}); end
      end
      if (k >= 2 && k <= 9) begin
        tests++; if (ret_v_o !== 4'(1 << ((k - 2) % 4))) begin fails++; $display("FAIL rr_ret_route k=%0d got %b exp %b", k, ret_v_o, 4'(1 << ((k - 2) % 4))); end
      end
      step();
    end
    ret_v_i = 1'b0;
    #1;
    tests++; if (ret_err_o !== 1'b0) begin fails++; $display("FAIL rr_no_err got %b exp 0", ret_err_o); end
    step();
  endtask

  task automatic test_per_source();
    int acc = 0;
    req_v_i = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      #1;
      tests++; if ((req_ready_o & 4'b1011) !== 4'b0) begin fails++; $display("FAIL per_other_ready k=%0d got %b exp 0", k, req_ready_o); end
      acc += int'(req_ready_o[2]);
      step();
    end
    tests++; if (acc != 8) begin fails++; $display("FAIL per_accepts got %0d exp 8", acc); end
    #1;
    tests++; if (req_ready_o !== 4'b0) begin fails++; $display("FAIL per_blocked got %b exp 0000", req_ready_o); end
    ret_v_i = 1'b1;
    ret_reg_id_i = 5'b10_001;
    #1;
    tests++; if (req_ready_o !== 4'b0100) begin fails++; $display("FAIL per_reuse got %b exp 0100", req_ready_o); end
    tests++; if (ret_v_o !== 4'b0100) begin fails++; $display("FAIL per_ret_route got %b exp 0100", ret_v_o); end
    step();
    ret_v_i = 1'b0;
    #1;
    tests++; if (req_ready_o !== 4'b0) begin fails++; $display("FAIL per_reblocked got %b exp 0000", req_ready_o); end
    req_v_i = '0;
    step();
    ret_n(2, 8);
  endtask

  task automatic test_global_limit();
    int acc = 0;
    req_v_i = 4'b0011;
    for (int k = 0; k < 20; k++) begin
      #1;
      acc += int'(|req_ready_o);
      step();
    end
    tests++; if (acc != 16) begin fails++; $display("FAIL glob_accepts got %0d exp 16", acc); end
    req_v_i = 4'b1011;
    #1;
    tests++; if (req_ready_o !== 4'b0) begin fails++; $display("FAIL glob_block_src3 got %b exp 0000", req_ready_o); end
    req_v_i = 4'b0011;
    ret_v_i = 1'b1;
    ret_reg_id_i = 5'b00_000;
    #1;
    tests++; if (req_ready_o !== 4'b0001) begin fails++; $display("FAIL glob_simul_grant got %b exp 0001", req_ready_o); end
    step();
    ret_v_i = 1'b0;
    req_v_i = 4'b1011;
    #1;
    tests++; if (req_ready_o !== 4'b0) begin fails++; $display("FAIL glob_still_full got %b exp 0000", req_ready_o); end
    req_v_i = '0;
    step();
    ret_n(0, 8);
    ret_n(1, 8);
  endtask

  task automatic test_backpressure();
    req_v_i = 4'b0010;
    out_ready_i = 1'b1;
    #1;
    tests++; if (req_ready_o !== 4'b0010) begin fails++; $display("FAIL bp_first got %b exp 0010", req_ready_o); end
    step();
    out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++; if (out_v_o !== 1'b1 || out_reg_id_o !== {2'd1, lid_tbl[1]}) begin fails++; $display("FAIL bp_hold k=%0d got v=%b id=%b exp v=1 id=%b", k, out_v_o, out_reg_id_o, {2'd1, lid_tbl[1]}); end
      tests++; if (out_payload_o !== pay_tbl[1]) begin fails++; $display("FAIL bp_payload k=%0d got %h exp %h", k, out_payload_o, pay_tbl[1]); end
      tests++; if (req_ready_o !== 4'b0) begin fails++; $display("FAIL bp_ready k=%0d got %b exp 0000", k, req_ready_o); end
      step();
    end
    out_ready_i = 1'b1;
    #1;
    tests++; if (req_ready_o !== 4'b0010) begin fails++; $display("FAIL bp_release got %b exp 0010", req_ready_o); end
    step();
    req_v_i = '0;
    #1;
    tests++; if (out_v_o !== 1'b1) begin fails++; $display("FAIL bp_new_entry got %b exp 1", out_v_o); end
    step();
    #1;
    tests++; if (out_v_o !== 1'b0) begin fails++; $display("FAIL bp_drained got %b exp 0", out_v_o); end
    ret_n(1, 2);
  endtask

  task automatic test_quiesce();
    req_v_i = 4'b0001;
    out_ready_i = 1'b1;
    #1;
    tests++; if (req_ready_o !== 4'b0001) begin fails++; $display("FAIL q_start got %b exp 0001", req_ready_o); end
    step();
    step();
    step();
    out_ready_i = 1'b0;
    quiesce_i = 1'b1;
    #1;
    tests++; if (req_ready_o !== 4'b0) begin fails++; $display("FAIL q_full got %b exp 0000", req_ready_o); end
    step();
    out_ready_i = 1'b1;
    #1;
    tests++; if (req_ready_o !== 4'b0 || out_v_o !== 1'b1) begin fails++; $display("FAIL q_drain got ready=%b v=%b exp ready=0000 v=1", req_ready_o, out_v_o); end
    step();
    for (int r = 0; r < 3; r++) begin
      ret_v_i = 1'b1;
      ret_reg_id_i = 5'b00_000;
      #1;
      tests++; if (idle_o !== 1'b0 || req_ready_o !== 4'b0 || out_v_o !== 1'b0)
        begin fails++; $display("FAIL q_pending r=%0d got idle=%b ready=%b v=%b exp 0 0000 0", r, idle_o, req_ready_o, out_v_o); end
      step();
    end
    ret_v_i = 1'b0;
    #1;
    tests++; if (idle_o !== 1'b1) begin fails++; $display("FAIL q_idle got %b exp 1", idle_o); end
    quiesce_i = 1'b0;
    #1;
    tests++; if (idle_o !== 1'b1 || req_ready_o !== 4'b0) begin fails++; $display("FAIL q_release got idle=%b ready=%b exp 1 0000", idle_o, req_ready_o); end
    step();
    #1;
    tests++; if (req_ready_o !== 4'b0001 || idle_o !== 1'b0) begin fails++; $display("FAIL q_resume got ready=%b idle=%b exp 0001 0", req_ready_o, idle_o); end
    step();
    req_v_i = '0;
    step();
    ret_n(0, 1);
  endtask

  task automatic test_error_reset();
    ret_v_i = 1'b1;
    ret_reg_id_i = 5'b11_010;
    ret_data_i = 32'hDEAD_BEEF;
    #1;
    tests++; if (ret_v_o !== 4'b1000) begin fails++; $display("FAIL err_route got %b exp 1000", ret_v_o); end
    tests++; if (ret_reg_id_o !== 3'b010 || ret_data_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL err_pass got id=%b data=%h exp 010 deadbeef", ret_reg_id_o, ret_data_o); end
    tests++; if (ret_err_o !== 1'b0) begin fails++; $display("FAIL err_not_yet got %b exp 0", ret_err_o); end
    step();
    ret_v_i = 1'b0;
    #1;
    tests++; if (ret_err_o !== 1'b1) begin fails++; $display("FAIL err_set got %b exp 1", ret_err_o); end
    step();
    #1;
    tests++; if (ret_err_o !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", ret_err_o); end
    req_v_i = 4'b1111;
    out_ready_i = 1'b1;
    step();
    step();
    step();
    #1;
    reset_i = 1'b1;
    #1;
    tests++; if (out_v_o !== 1'b0 || req_ready_o !== 4'b0) begin fails++; $display("FAIL rst_async got v=%b ready=%b exp 0 0000", out_v_o, req_ready_o); end
    tests++; if (ret_err_o !== 1'b0 || idle_o !== 1'b0) begin fails++; $display("FAIL rst_async_flags got err=%b idle=%b exp 0 0", ret_err_o, idle_o); end
    #1;
    reset_i = 1'b0;
    #1;
    tests++; if (req_ready_o !== 4'b0001) begin fails++; $display("FAIL rst_first_grant got %b exp 0001", req_ready_o); end
    req_v_i = '0;
    step();
    ret_v_i = 1'b1;
    ret_reg_id_i = 5'b01_000;
    step();
    ret_v_i = 1'b0;
    #1;
    tests++; if (ret_err_o !== 1'b1) begin fails++; $display("FAIL rst_stale_ret got %b exp 1", ret_err_o); end
  endtask

  initial begin
    reset_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      pay_tbl[i] = {32'hA5A5_0000 + 32'(i), 64'h0123_4567_89AB_CDEF ^ 64'(i)};
      lid_tbl[i] = LW'(i + 3);
      req_payload_i[i] = pay_tbl[i];
      req_reg_id_i[i] = lid_tbl[i];
    end
    req_v_i = 4'b1111;
    out_ready_i = 1'b0;
    ret_v_i = 1'b0;
    ret_reg_id_i = '0;
    ret_data_i = '0;
    quiesce_i = 1'b0;
    test_reset();
    test_round_robin();
    test_per_source();
    test_global_limit();
    test_backpressure();
    test_quiesce();
    test_error_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
